x_frame_loader: RTL and testbench

Writer side of the autocorrelation sample memory. Accepts 80 new 16-bit speech samples per G.729 frame over a valid/ready stream and maintains the 240-sample LPC analysis window in the x memory. It shifts the 160 retained samples down by 80 locations, appends the new frame at addresses 160–239, then pulses `autocorrStart` and holds off until the autocorrelation block reports `autocorrDone`.

---
 rtl/x_frame_loader_if.sv | 27 ++
 rtl/x_frame_loader.sv | 132 +++++++++++++
 tb/tb_x_frame_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/x_frame_loader_if.sv
// Signal bundle between the frame loader, the sample source, the x memory
// and the autocorrelation engine.
interface x_frame_loader_if;
    // Sample stream: a sample transfers on a rising clk edge where sampleValid
    // and sampleReady are both high; the source holds sampleIn steady until then.
    logic [15:0] sampleIn;
    logic        sampleValid;
    logic        sampleReady;
    logic [7:0]  xMemAddr;
    logic [31:0] xMemWriteData;
    logic        xMemEn;
    logic [31:0] xMemReadData;
    logic        autocorrStart;
    logic        autocorrDone;
    logic        busy;
    logic [2:0]  dbg_state;

    modport master (
        input  sampleIn, sampleValid, xMemReadData, autocorrDone,
        output sampleReady, xMemAddr, xMemWriteData, xMemEn, autocorrStart, busy, dbg_state
    );

    modport slave (
        output sampleIn, sampleValid, xMemReadData, autocorrDone,
        input  sampleReady, xMemAddr, xMemWriteData, xMemEn, autocorrStart, busy, dbg_state
    );
endinterface

// File: rtl/x_frame_loader.sv
// Maintains the 240-word LPC analysis window in x memory: shifts the retained
// samples down one frame, appends the new frame, then kicks autocorrelation.
module x_frame_loader #(
    parameter int FRAME  = 80,
    parameter int WINDOW = 240
) (
    input  logic               clk,
    input  logic               reset,
    x_frame_loader_if.master   bus
);

    localparam logic [7:0] RETAIN_LAST = 8'(WINDOW - FRAME - 1);
    localparam logic [7:0] FRAME_LAST  = 8'(FRAME - 1);
    localparam logic [7:0] SHIFT_OFS   = 8'(FRAME);
    localparam logic [7:0] LOAD_BASE   = 8'(WINDOW - FRAME);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_SHIFT_RD = 3'd2,
        S_SHIFT_WR = 3'd3,
        S_LOAD     = 3'd4,
        S_START    = 3'd5,
        S_WAIT     = 3'd6
    } state_t;

    state_t     state, nxt_state;
    logic [7:0] i, nxt_i;
    logic       primed;
    logic       ready_q, start_q, busy_q;
    logic       accept;

    assign accept = (state == S_LOAD) && ready_q && bus.sampleValid;

    always_comb begin
        nxt_state = state;
        nxt_i     = i;
        case (state)
            S_IDLE: begin
                if (bus.sampleValid) begin
                    nxt_state = primed ? S_SHIFT_RD : S_CLEAR;
                    nxt_i     = '0;
                end
            end
            S_CLEAR: begin
                if (i == RETAIN_LAST) begin
                    nxt_state = S_LOAD;
                    nxt_i     = '0;
                end else begin
                    nxt_i = i + 8'd1;
                end
            end
            S_SHIFT_RD: nxt_state = S_SHIFT_WR;
            S_SHIFT_WR: begin
                if (i == RETAIN_LAST) begin
                    nxt_state = S_LOAD;
                    nxt_i     = '0;
                end else begin
                    nxt_state = S_SHIFT_RD;
                    nxt_i     = i + 8'd1;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (i == FRAME_LAST) begin
                        nxt_state = S_START;
                        nxt_i     = '0;
                    end else begin
                        nxt_i = i + 8'd1;
                    end
                end
            end
            S_START: nxt_state = S_WAIT;
            S_WAIT: begin
                if (bus.autocorrDone) nxt_state = S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Memory port decodes straight from the state/index registers; the write data
    // in SHIFT_WR must be the read data returned for the preceding SHIFT_RD.
    always_comb begin
        bus.xMemAddr      = '0;
        bus.xMemWriteData = '0;
        bus.xMemEn        = 1'b0;
        case (state)
            S_CLEAR: begin
                bus.xMemAddr = i;
                bus.xMemEn   = 1'b1;
            end
            S_SHIFT_RD: bus.xMemAddr = i + SHIFT_OFS;
            S_SHIFT_WR: begin
                bus.xMemAddr      = i;
                bus.xMemWriteData = bus.xMemReadData;
                bus.xMemEn        = 1'b1;
            end
            S_LOAD: begin
                if (accept) begin
                    bus.xMemAddr      = LOAD_BASE + i;
                    bus.xMemWriteData = {{16{bus.sampleIn[15]}}, bus.sampleIn};
                    bus.xMemEn        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            i       <= '0;
            primed  <= 1'b0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= nxt_state;
            i       <= nxt_i;
            ready_q <= (nxt_state == S_LOAD);
            start_q <= (nxt_state == S_START);
            busy_q  <= (nxt_state != S_IDLE);
            if (nxt_state == S_START) primed <= 1'b1;
        end
    end

    assign bus.sampleReady   = ready_q;
    assign bus.autocorrStart = start_q;
    assign bus.busy          = busy_q;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_x_frame_loader.sv
// Directed bench for x_frame_loader with an x-memory model and a write scoreboard.
module tb_x_frame_loader;

    logic clk = 1'b0;
    logic reset;

    x_frame_loader_if bus();

    x_frame_loader #(.FRAME(80), .WINDOW(240)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:239];
    logic [31:0] rdata_q = 32'h0;
    assign bus.xMemReadData = rdata_q;

    logic [39:0] exp_q[$];
    logic [39:0] sb_e;
    int lo_wr, lo_zero, hi_wr, start_cnt;

    logic [15:0] frame_vals [0:79];
    int          frame_gaps [0:79];
    int          done_pulse_at;
    bit          done_early;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: synchronous write, read data registered one cycle after address.
    always @(posedge clk) begin
        if (bus.xMemEn) begin
            if (bus.xMemAddr < 8'd240) mem[bus.xMemAddr] <= bus.xMemWriteData;
        end else begin
            rdata_q <= (bus.xMemAddr < 8'd240) ? mem[bus.xMemAddr] : 32'hDEAD_BEEF;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (bus.xMemEn) begin
                if (bus.xMemAddr >= 8'd160) begin
                    hi_wr++;
                    if (exp_q.size() == 0) begin
                        check("sb_extra_write", {24'd0, bus.xMemAddr}, 32'hFFFF_FFFF);
                    end else begin
                        sb_e = exp_q.pop_front();
                        check("sb_addr", {24'd0, bus.xMemAddr}, {24'd0, sb_e[39:32]});
                        check("sb_data", bus.xMemWriteData, sb_e[31:0]);
                    end
                end else begin
                    lo_wr++;
                    if (bus.xMemWriteData == 32'd0) lo_zero++;
                end
            end
            if (bus.autocorrStart) start_cnt++;
        end
    end

    task automatic clear_counts();
        lo_wr = 0; lo_zero = 0; hi_wr = 0; start_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, bus.sampleReady, 0);
        check({tag, "_addr"}, bus.xMemAddr, 0);
        check({tag, "_wdata"}, bus.xMemWriteData, 0);
        check({tag, "_en"}, bus.xMemEn, 0);
        check({tag, "_start"}, bus.autocorrStart, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_state"}, bus.dbg_state, 0);
    endtask

    task automatic check_region(input string tag, input int lo, input int hi,
                                input int first, input int step);
        for (int a = lo; a <= hi; a++)
            check($sformatf("%s[%0d]", tag, a), mem[a], 32'(first + (a - lo) * step));
    endtask

    task automatic send_sample(input logic [15:0] s, input int gaps, input int idx);
        int guard;
        for (int g = 0; g < gaps; g++) begin
            bus.sampleValid = 1'b0;
            #1;
            check("gap_no_write", bus.xMemEn, 0);
            @(posedge clk); #1;
        end
        bus.sampleIn    = s;
        bus.sampleValid = 1'b1;
        exp_q.push_back({8'(160 + idx), {{16{s[15]}}, s}});
        guard = 0;
        while (!bus.sampleReady && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_ready", bus.sampleReady, 1);
        @(posedge clk); #1;
    endtask

    task automatic begin_frame(input int exp_lat);
        int lat;
        bus.sampleIn    = frame_vals[0];
        bus.sampleValid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.sampleReady && lat < 1000);
        check("ready_latency", lat, exp_lat);
        check("busy_in_load", bus.busy, 1);
    endtask

    task automatic load_frame(input int exp_lat, input bit hold_valid);
        begin_frame(exp_lat);
        for (int k = 0; k < 80; k++) begin
            if (k == done_pulse_at) bus.autocorrDone = 1'b1;
            if (done_early && k == 79) bus.autocorrDone = 1'b1;
            if (frame_vals[k] == 16'h8001 || frame_vals[k] == 16'h7FFF) begin
                bus.sampleIn    = frame_vals[k];
                bus.sampleValid = 1'b1;
                #1;
                check("sext_en", bus.xMemEn, 1);
                check("sext_data", bus.xMemWriteData,
                      (frame_vals[k] == 16'h8001) ? 32'hFFFF_8001 : 32'h0000_7FFF);
            end
            send_sample(frame_vals[k], frame_gaps[k], k);
            if (k == done_pulse_at) bus.autocorrDone = 1'b0;
        end
        check("start_after_last", bus.autocorrStart, 1);
        check("ready_drop", bus.sampleReady, 0);
        if (!hold_valid) bus.sampleValid = 1'b0;
        @(posedge clk); #1;
        check("start_one_cycle", bus.autocorrStart, 0);
        check("busy_in_wait", bus.busy, 1);
        check("start_count", start_cnt, 1);
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic finish_frame();
        check("state_wait", bus.dbg_state, 6);
        bus.autocorrDone = 1'b1;
        bus.sampleValid  = 1'b0;
        @(posedge clk); #1;
        bus.autocorrDone = 1'b0;
        check("busy_after_done", bus.busy, 0);
        check("idle_after_done", bus.dbg_state, 0);
    endtask

    initial begin
        int wr_before;
        reset = 1'b0;
        bus.sampleIn = '0;
        bus.sampleValid = 1'b0;
        bus.autocorrDone = 1'b0;
        done_pulse_at = -1;
        done_early = 1'b0;
        for (int a = 0; a < 240; a++) mem[a] = 32'hA5A5_A5A5;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // Frame 1: unprimed, continuous samples 1..80.
        for (int k = 0; k < 80; k++) begin frame_vals[k] = 16'(k + 1); frame_gaps[k] = 0; end
        clear_counts();
        load_frame(161, 1'b0);
        check("f1_clear_writes", lo_wr, 160);
        check("f1_clear_zero", lo_zero, 160);
        check("f1_load_writes", hi_wr, 80);
        repeat (3) begin @(posedge clk); #1; end
        check("f1_wait_holds", bus.busy, 1);
        finish_frame();
        check_region("f1_mem", 0, 159, 0, 0);
        check_region("f1_mem", 160, 239, 1, 1);

        // Frame 2: primed, samples 101..180, valid held high through WAIT.
        for (int k = 0; k < 80; k++) frame_vals[k] = 16'(k + 101);
        clear_counts();
        load_frame(321, 1'b1);
        bus.sampleIn = 16'h1234;
        wr_before = lo_wr + hi_wr;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("wait_ready_low", bus.sampleReady, 0);
        end
        check("wait_no_writes", lo_wr + hi_wr, wr_before);
        check("f2_shift_writes", lo_wr, 160);
        check("f2_load_writes", hi_wr, 80);
        finish_frame();
        check_region("f2_mem", 0, 79, 0, 0);
        check_region("f2_mem", 80, 159, 1, 1);
        check_region("f2_mem", 160, 239, 101, 1);

        // Frame 3: two-cycle gaps, sign-extension corners, stray done during LOAD.
        for (int k = 0; k < 80; k++) begin
            frame_vals[k] = 16'h0200 + 16'(k);
            frame_gaps[k] = (k % 5 == 3) ? 2 : 0;
        end
        frame_vals[10] = 16'h8001;
        frame_vals[11] = 16'h7FFF;
        done_pulse_at = 20;
        clear_counts();
        load_frame(321, 1'b0);
        done_pulse_at = -1;
        check("f3_shift_writes", lo_wr, 160);
        check("f3_load_writes", hi_wr, 80);
        finish_frame();
        check_region("f3_mem", 0, 79, 1, 1);
        check_region("f3_mem", 80, 159, 101, 1);
        check("f3_mem160", mem[160], 32'h0000_0200);
        check("f3_mem170", mem[170], 32'hFFFF_8001);
        check("f3_mem171", mem[171], 32'h0000_7FFF);
        check("f3_mem239", mem[239], 32'h0000_024F);

        // Frame 4: reset after 40 accepts.
        for (int k = 0; k < 80; k++) begin frame_vals[k] = 16'h0300 + 16'(k); frame_gaps[k] = 0; end
        clear_counts();
        begin_frame(321);
        for (int k = 0; k < 40; k++) send_sample(frame_vals[k], 0, k);
        check("f4_partial_writes", hi_wr, 40);
        reset = 1'b0;
        bus.sampleValid = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("f4_sb_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Frame 5: back to CLEAR; done already high when WAIT is entered.
        for (int k = 0; k < 80; k++) frame_vals[k] = 16'(k + 1);
        for (int a = 0; a < 160; a++) mem[a] = 32'h5A5A_5A5A;
        clear_counts();
        done_early = 1'b1;
        load_frame(161, 1'b0);
        done_early = 1'b0;
        check("f5_clear_writes", lo_wr, 160);
        check("f5_clear_zero", lo_zero, 160);
        @(posedge clk); #1;
        bus.autocorrDone = 1'b0;
        check("f5_early_done_idle", bus.dbg_state, 0);
        check("f5_early_done_busy", bus.busy, 0);
        check_region("f5_mem", 0, 159, 0, 0);
        check_region("f5_mem", 160, 239, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
